mem_stage: RTL and testbench

Memory-access stage of the five-stage pipeline, sitting directly downstream of the EX/MEM pipeline register and upstream of the MEM/WB register. It turns the registered load/store controls into a request/acknowledge transaction on the data-memory port. While the transaction is outstanding it stalls the front of the pipe. It then presents the writeback result, either load data or the pass-through ALU result, as registered outputs for exactly one cycle per instruction.

---
 rtl/mem_stage.sv | 131 +++++++++++++
 tb/tb_mem_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: turns EX/MEM load/store controls into a req/ack data-memory
// transaction and registers the writeback result. Optional ack watchdog: MEM_TIMEOUT_EN.
module mem_stage #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_valid,
    input  logic                  mem_mem_re,
    input  logic                  mem_mem_we,
    input  logic [ADDR_W-1:0]     mem_mem_addr,
    input  logic [DATA_W-1:0]     mem_store_data,
    input  logic [DATA_W-1:0]     mem_data,
    input  logic                  mem_regfile_we,
    input  logic [REG_ADDR_W-1:0] mem_regfile_waddr,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_W-1:0]     dmem_addr,
    output logic [DATA_W-1:0]     dmem_wdata,
    input  logic                  dmem_ack,
    input  logic [DATA_W-1:0]     dmem_rdata,
    output logic                  stall_req,
    output logic                  wb_valid,
    output logic                  wb_regfile_we,
    output logic [REG_ADDR_W-1:0] wb_regfile_waddr,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  mem_err
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                  state_q;
    logic                    is_load_q;
    logic                    rf_we_q;
    logic [REG_ADDR_W-1:0]   waddr_q;
    logic [DATA_W-1:0]       alu_q;
    logic                    mem_op;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    assign mem_err = err_q;
`else
    assign mem_err = 1'b0;
`endif

    assign mem_op = mem_valid & (mem_mem_re | mem_mem_we);

    // Drops in the ack cycle so upstream advances on the edge that retires the access.
    assign stall_req = ((state_q == IDLE) & mem_op) | ((state_q == BUSY) & ~dmem_ack);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= IDLE;
            dmem_req         <= 1'b0;
            dmem_we          <= 1'b0;
            dmem_addr        <= '0;
            dmem_wdata       <= '0;
            wb_valid         <= 1'b0;
            wb_regfile_we    <= 1'b0;
            wb_regfile_waddr <= '0;
            wb_data          <= '0;
            is_load_q        <= 1'b0;
            rf_we_q          <= 1'b0;
            waddr_q          <= '0;
            alu_q            <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt_q            <= '0;
            err_q            <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_op) begin
                        // Store takes precedence when re and we are both set.
                        dmem_req      <= 1'b1;
                        dmem_we       <= mem_mem_we;
                        dmem_addr     <= mem_mem_addr;
                        dmem_wdata    <= mem_store_data;
                        is_load_q     <= ~mem_mem_we;
                        rf_we_q       <= mem_regfile_we;
                        waddr_q       <= mem_regfile_waddr;
                        alu_q         <= mem_data;
                        wb_valid      <= 1'b0;
                        wb_regfile_we <= 1'b0;
`ifdef MEM_TIMEOUT_EN
                        cnt_q         <= '0;
`endif
                        state_q       <= BUSY;
                    end else begin
                        wb_valid         <= mem_valid;
                        wb_data          <= mem_data;
                        wb_regfile_waddr <= mem_regfile_waddr;
                        wb_regfile_we    <= mem_valid & mem_regfile_we & (|mem_regfile_waddr);
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        dmem_req         <= 1'b0;
                        wb_valid         <= 1'b1;
                        wb_data          <= is_load_q ? dmem_rdata : alu_q;
                        wb_regfile_waddr <= waddr_q;
                        wb_regfile_we    <= rf_we_q & (|waddr_q);
                        state_q          <= IDLE;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (cnt_q == CNT_LAST) begin
                        // Abandon the access and retire a harmless slot.
                        dmem_req         <= 1'b0;
                        wb_valid         <= 1'b1;
                        wb_data          <= alu_q;
                        wb_regfile_waddr <= waddr_q;
                        wb_regfile_we    <= 1'b0;
                        err_q            <= 1'b1;
                        state_q          <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed table-driven bench for mem_stage, plus hand sequences for reset and timeout.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        mem_valid, mem_mem_re, mem_mem_we;
    logic [31:0] mem_mem_addr, mem_store_data, mem_data;
    logic        mem_regfile_we;
    logic [4:0]  mem_regfile_waddr;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall_req, wb_valid, wb_regfile_we;
    logic [4:0]  wb_regfile_waddr;
    logic [31:0] wb_data;
    logic        mem_err;

    int errors = 0;
    int checks = 0;

    mem_stage #(.ADDR_W(32), .DATA_W(32), .REG_ADDR_W(5), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_mem_re(mem_mem_re), .mem_mem_we(mem_mem_we),
        .mem_mem_addr(mem_mem_addr), .mem_store_data(mem_store_data), .mem_data(mem_data),
        .mem_regfile_we(mem_regfile_we), .mem_regfile_waddr(mem_regfile_waddr),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall_req(stall_req),
        .wb_valid(wb_valid), .wb_regfile_we(wb_regfile_we),
        .wb_regfile_waddr(wb_regfile_waddr), .wb_data(wb_data), .mem_err(mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v, re, we;
        logic [31:0] addr, sd, d;
        logic        rfwe;
        logic [4:0]  wa;
        logic        ack;
        logic [31:0] rd;
        logic        x_stall, x_req, x_dwe;
        logic [31:0] x_addr, x_wdata;
        logic        x_wbv, x_wbwe;
        logic [4:0]  x_wa;
        logic [31:0] x_wd;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, re, we, input logic [31:0] addr, sd, d,
                         input logic rfwe, input logic [4:0] wa, input logic ack,
                         input logic [31:0] rd);
        mem_valid = v; mem_mem_re = re; mem_mem_we = we;
        mem_mem_addr = addr; mem_store_data = sd; mem_data = d;
        mem_regfile_we = rfwe; mem_regfile_waddr = wa;
        dmem_ack = ack; dmem_rdata = rd;
    endtask

    function automatic vec_t mk(logic v, re, we, logic [31:0] addr, sd, d, logic rfwe,
                                logic [4:0] wa, logic ack, logic [31:0] rd,
                                logic x_stall, x_req, x_dwe, logic [31:0] x_addr, x_wdata,
                                logic x_wbv, x_wbwe, logic [4:0] x_wa, logic [31:0] x_wd);
        vec_t t;
        t.v = v; t.re = re; t.we = we; t.addr = addr; t.sd = sd; t.d = d;
        t.rfwe = rfwe; t.wa = wa; t.ack = ack; t.rd = rd;
        t.x_stall = x_stall; t.x_req = x_req; t.x_dwe = x_dwe;
        t.x_addr = x_addr; t.x_wdata = x_wdata;
        t.x_wbv = x_wbv; t.x_wbwe = x_wbwe; t.x_wa = x_wa; t.x_wd = x_wd;
        return t;
    endfunction

    initial begin
        int busy;
        // inputs: v re we addr sd d rfwe wa ack rd | stall | after edge: req dwe addr wdata wbv wbwe wa wd
        vecs[0]  = mk(1,0,0, 0, 0, 32'h1234, 1, 3, 0, 0,         0, 0,0, 0, 0,                    1,1, 3, 32'h1234);
        vecs[1]  = mk(1,0,0, 0, 0, 32'h55,   1, 0, 0, 0,         0, 0,0, 0, 0,                    1,0, 0, 32'h55);
        vecs[2]  = mk(0,0,0, 0, 0, 32'h99,   1, 5, 0, 0,         0, 0,0, 0, 0,                    0,0, 5, 32'h99);
        vecs[3]  = mk(1,1,0, 32'h40, 0, 32'h1111, 1, 7, 0, 0,    1, 1,0, 32'h40, 0,               0,0, 5, 32'h99);
        vecs[4]  = mk(1,1,0, 32'h40, 0, 32'h1111, 1, 7, 0, 0,    1, 1,0, 32'h40, 0,               0,0, 5, 32'h99);
        vecs[5]  = mk(1,1,0, 32'h40, 0, 32'h1111, 1, 7, 1, 32'hDEADBEEF,
                                                                 0, 0,0, 32'h40, 0,               1,1, 7, 32'hDEADBEEF);
        vecs[6]  = mk(1,0,1, 32'h80, 32'hA5A5A5A5, 32'h2222, 0, 2, 0, 0,
                                                                 1, 1,1, 32'h80, 32'hA5A5A5A5,    0,0, 7, 32'hDEADBEEF);
        vecs[7]  = mk(1,0,1, 32'h80, 32'hA5A5A5A5, 32'h2222, 0, 2, 1, 32'h0BAD,
                                                                 0, 0,1, 32'h80, 32'hA5A5A5A5,    1,0, 2, 32'h2222);
        vecs[8]  = mk(1,0,0, 0, 0, 32'h3333, 1, 4, 1, 32'hBAD,   0, 0,1, 32'h80, 32'hA5A5A5A5,    1,1, 4, 32'h3333);
        vecs[9]  = mk(1,1,0, 32'h44, 0, 0, 1, 8, 0, 0,           1, 1,0, 32'h44, 0,               0,0, 4, 32'h3333);
        vecs[10] = mk(1,1,0, 32'h44, 0, 0, 1, 8, 1, 32'h0BADF00D,
                                                                 0, 0,0, 32'h44, 0,               1,1, 8, 32'h0BADF00D);
        vecs[11] = mk(1,0,0, 0, 0, 32'h10, 1, 9, 0, 0,           0, 0,0, 32'h44, 0,               1,1, 9, 32'h10);
        vecs[12] = mk(1,0,0, 0, 0, 32'h20, 1, 10, 0, 0,          0, 0,0, 32'h44, 0,               1,1, 10, 32'h20);
        vecs[13] = mk(0,0,0, 0, 0, 0, 0, 0, 0, 0,                0, 0,0, 32'h44, 0,               0,0, 0, 0);
        vecs[14] = mk(1,1,1, 32'h90, 32'h77, 32'h5, 1, 6, 0, 0,  1, 1,1, 32'h90, 32'h77,          0,0, 0, 0);
        vecs[15] = mk(1,1,1, 32'h90, 32'h77, 32'h5, 1, 6, 1, 32'hFFFF,
                                                                 0, 0,1, 32'h90, 32'h77,          1,1, 6, 32'h5);
        vecs[16] = mk(0,1,0, 32'hC0, 0, 32'h66, 1, 1, 0, 0,      0, 0,1, 32'h90, 32'h77,          0,0, 1, 32'h66);

        rst = 1'b0;
        drive(0,0,0, 0,0,0, 0,0, 0,0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset dmem_req", {31'b0, dmem_req}, 0);
        chk("reset wb_valid", {31'b0, wb_valid}, 0);
        chk("reset wb_data", wb_data, 0);
        chk("reset stall_req", {31'b0, stall_req}, 0);
        chk("reset mem_err", {31'b0, mem_err}, 0);
        rst = 1'b1;

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].v, vecs[i].re, vecs[i].we, vecs[i].addr, vecs[i].sd, vecs[i].d,
                  vecs[i].rfwe, vecs[i].wa, vecs[i].ack, vecs[i].rd);
            #1;
            chk($sformatf("v%0d stall_req", i), {31'b0, stall_req}, {31'b0, vecs[i].x_stall});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d dmem_req", i), {31'b0, dmem_req}, {31'b0, vecs[i].x_req});
            chk($sformatf("v%0d dmem_we", i), {31'b0, dmem_we}, {31'b0, vecs[i].x_dwe});
            chk($sformatf("v%0d dmem_addr", i), dmem_addr, vecs[i].x_addr);
            chk($sformatf("v%0d dmem_wdata", i), dmem_wdata, vecs[i].x_wdata);
            chk($sformatf("v%0d wb_valid", i), {31'b0, wb_valid}, {31'b0, vecs[i].x_wbv});
            chk($sformatf("v%0d wb_regfile_we", i), {31'b0, wb_regfile_we}, {31'b0, vecs[i].x_wbwe});
            chk($sformatf("v%0d wb_regfile_waddr", i), {27'b0, wb_regfile_waddr}, {27'b0, vecs[i].x_wa});
            chk($sformatf("v%0d wb_data", i), wb_data, vecs[i].x_wd);
            chk($sformatf("v%0d mem_err", i), {31'b0, mem_err}, 0);
        end

        // Reset mid-transaction: outputs clear without waiting for a clock edge.
        drive(1,1,0, 32'h100, 0, 0, 1, 3, 0, 0);
        @(posedge clk);
        #1;
        chk("midreset req before", {31'b0, dmem_req}, 1);
        #2;
        rst = 1'b0;
        mem_valid = 1'b0;
        #1;
        chk("midreset dmem_req", {31'b0, dmem_req}, 0);
        chk("midreset wb_valid", {31'b0, wb_valid}, 0);
        chk("midreset stall_req", {31'b0, stall_req}, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1,0,0, 0, 0, 32'hABCD, 1, 12, 0, 0);
        #1;
        chk("postreset stall_req", {31'b0, stall_req}, 0);
        @(posedge clk);
        #1;
        chk("postreset wb_valid", {31'b0, wb_valid}, 1);
        chk("postreset wb_data", wb_data, 32'hABCD);
        chk("postreset wb_regfile_we", {31'b0, wb_regfile_we}, 1);

`ifdef MEM_TIMEOUT_EN
        // Load that is never acknowledged: watchdog retires it after 4 BUSY cycles.
        drive(1,1,0, 32'h200, 0, 32'h42, 1, 5, 0, 0);
        @(posedge clk);
        #1;
        busy = 0;
        for (int k = 0; k < 20; k++) begin
            if (!dmem_req) break;
            chk($sformatf("timeout wb_valid busy%0d", busy), {31'b0, wb_valid}, 0);
            busy++;
            @(posedge clk);
            #1;
        end
        mem_valid = 1'b0;
        chk("timeout busy cycles", busy, 4);
        chk("timeout wb_valid", {31'b0, wb_valid}, 1);
        chk("timeout wb_regfile_we", {31'b0, wb_regfile_we}, 0);
        chk("timeout mem_err", {31'b0, mem_err}, 1);
        drive(1,0,0, 0, 0, 32'h7, 1, 3, 0, 0);
        @(posedge clk);
        #1;
        chk("timeout mem_err sticky", {31'b0, mem_err}, 1);
        chk("timeout next wb_data", wb_data, 32'h7);
        rst = 1'b0;
        #1;
        chk("timeout mem_err cleared", {31'b0, mem_err}, 0);
        rst = 1'b1;
`else
        busy = 0;
        drive(1,1,0, 32'h200, 0, 32'h42, 1, 5, 0, 0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 20; k++) begin
            if (dmem_req) busy++;
            @(posedge clk);
            #1;
        end
        chk("no-timeout busy held", busy, 20);
        chk("no-timeout mem_err", {31'b0, mem_err}, 0);
        chk("no-timeout stall_req", {31'b0, stall_req}, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
